uart_tx_8n1: RTL and testbench
==============================

# uart_tx_8n1

Transmit-only UART serializer producing 8N1 frames: one start bit, eight data bits LSB first, one stop bit, no parity. It accepts one byte per request strobe and reports busy/complete status back to the requester. In the top level it drives the board UART TX pin and streams the startup banner and hex dump lines from the capture buffer. Bit timing is a fixed integer divide of the system clock.

## Interface
- CLKS_PER_BIT, default 868 (100 MHz / 115200 baud): system clock cycles per serial bit; legal range 2..65535.
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_TX_DV  input  1  transmit request; sampled only in IDLE.
- i_TX_Byte  input  8  byte to send; captured on the accepting edge.
- o_TX_Active  output  1  high while a frame (start..stop bit) is on the line.
- o_TX_Serial  output  1  serial line; idles high.
- o_TX_Done  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, STOP, CLEANUP.
- Reset (async): state=IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, bit counter=0, bit index=0, data register=0. Takes effect immediately, including mid-frame; the line returns high at once. i_TX_DV asserted during reset is ignored.
- IDLE: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0. On an edge with i_TX_DV=1: latch i_TX_Byte, set o_TX_Active=1, o_TX_Serial=0, clear the counter, go to START.
- START: hold 0 for CLKS_PER_BIT cycles, then drive data bit 0 and go to DATA with index 0.
- DATA: hold bit[index] for CLKS_PER_BIT cycles. After index 7, drive 1 and go to STOP. Otherwise increment index and drive the next bit.
- STOP: hold 1 for CLKS_PER_BIT cycles, then set o_TX_Active=0, o_TX_Done=1 and go to CLEANUP.
- CLEANUP: one cycle. o_TX_Done=1, line high. Then o_TX_Done=0 and go to IDLE.
- i_TX_DV outside IDLE is ignored. No queuing. Changes to i_TX_Byte after acceptance do not affect the frame in flight.
- If i_TX_DV is held high continuously, a new frame starts on the first IDLE edge, giving back-to-back frames.
- Counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and clears at every bit boundary. No overflow is possible.

## Timing
- Let E0 be the accepting edge. All signals are registered.
- o_TX_Active and the start bit appear immediately after E0, giving one cycle of latency.
- Start bit covers [E0, E0+CPB). Data bit i covers [E0+(1+i)·CPB, E0+(2+i)·CPB). The stop bit covers [E0+9·CPB, E0+10·CPB).
- At E0+10·CPB, o_TX_Active falls and o_TX_Done rises. At E0+10·CPB+1, o_TX_Done falls and the state is IDLE.
- The earliest next accepting edge is E0+10·CPB+1, so the back-to-back frame period is 10·CPB+1 cycles.
- o_TX_Active and o_TX_Done are never high in the same cycle.

## Test plan
- Reset behaviour: assert reset with DV=1 -> Serial=1, Active=0, Done=0 throughout; no frame starts until after reset is released.
- Single byte: CPB=4, send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each level 4 cycles. Active is high for exactly 40 cycles and Done pulses for 1 cycle at cycle 40.
- Byte capture and DV blocking: send 0x00, then change i_TX_Byte to 0xFF and pulse DV mid-frame -> all-zero frame is sent unaltered and the mid-frame DV is ignored; no second frame follows.
- Back-to-back: CPB=4, DV held high, bytes 0x55 then 0x0F -> second start bit begins exactly 41 cycles after the first; both frames decode correctly.
- Reset mid-frame: CPB=8, assert reset during bit 3 of 0x3C -> Serial goes to 1 and Active to 0 asynchronously with no Done pulse; a following send of 0x81 is transmitted cleanly.
- Default divide: CPB=868, send 0xFF -> start bit lasts 868 cycles and the frame lasts 8680 cycles.

Source files
------------

// File: rtl/uart_tx_8n1_if.sv
// rtl/uart_tx_8n1_if.sv - request/status bundle between a byte source and the 8N1 transmitter
//
// Signals:
//   tx_dv      requester -> tx  transmit request, sampled only while idle
//   tx_byte    requester -> tx  byte to send, captured on the accepting edge
//   tx_active  tx -> requester  high while a frame (start..stop bit) is on the line
//   tx_serial  tx -> pin        serial line, idles high
//   tx_done    tx -> requester  one-cycle pulse when a frame completes
interface uart_tx_8n1_if;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;

    modport master (
        output tx_dv,
        output tx_byte,
        input  tx_active,
        input  tx_serial,
        input  tx_done
    );

    modport slave (
        input  tx_dv,
        input  tx_byte,
        output tx_active,
        output tx_serial,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - transmit-only 8N1 UART serializer with fixed clock divide
//
// Ports:
//   clk  system clock, all logic on its rising edge
//   rst  asynchronous active-high reset; line returns high immediately
//   tx   uart_tx_8n1_if.slave: tx_dv/tx_byte request in, tx_active/tx_serial/tx_done out
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit, 2..65535
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_8n1_if.slave  tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       data, data_nxt;
    logic             serial_q, active_q, done_q;
    logic             serial_nxt, active_nxt, done_nxt;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // State register; outputs are registered from the next-state decode so
    // every output is a flop and lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            data     <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            data     <= data_nxt;
            serial_q <= serial_nxt;
            active_q <= active_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next-state decode. CLEANUP is the final cycle of a frame; a request on
    // its closing edge is taken as an idle acceptance so a held request gives
    // a frame period of 10*CLKS_PER_BIT+1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        data_nxt  = data;
        case (state)
            IDLE, CLEANUP: begin
                state_nxt = IDLE;
                if (tx.tx_dv) begin
                    data_nxt  = tx.tx_byte;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    state_nxt = CLEANUP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Output decode from the state being entered.
    always_comb begin
        serial_nxt = 1'b1;
        active_nxt = 1'b0;
        done_nxt   = 1'b0;
        case (state_nxt)
            START: begin
                serial_nxt = 1'b0;
                active_nxt = 1'b1;
            end
            DATA: begin
                serial_nxt = data_nxt[idx_nxt];
                active_nxt = 1'b1;
            end
            STOP: begin
                active_nxt = 1'b1;
            end
            CLEANUP: begin
                done_nxt = 1'b1;
            end
            default: begin
                serial_nxt = 1'b1;
            end
        endcase
    end

    assign tx.tx_serial = serial_q;
    assign tx.tx_active = active_q;
    assign tx.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb/tb_uart_tx_8n1.sv - self-checking bench for uart_tx_8n1 with directed vectors
module tb_uart_tx_8n1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_tx_8n1_if if4();
    uart_tx_8n1_if if8();
    uart_tx_8n1_if if868();

    uart_tx_8n1 #(.CLKS_PER_BIT(4))   dut4   (.clk(clk), .rst(rst), .tx(if4.slave));
    uart_tx_8n1 #(.CLKS_PER_BIT(8))   dut8   (.clk(clk), .rst(rst), .tx(if8.slave));
    uart_tx_8n1 #(.CLKS_PER_BIT(868)) dut868 (.clk(clk), .rst(rst), .tx(if868.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_dv(input int sel, input logic v);
        case (sel)
            0:       if4.tx_dv   = v;
            1:       if8.tx_dv   = v;
            default: if868.tx_dv = v;
        endcase
    endtask

    task automatic set_byte(input int sel, input logic [7:0] b);
        case (sel)
            0:       if4.tx_byte   = b;
            1:       if8.tx_byte   = b;
            default: if868.tx_byte = b;
        endcase
    endtask

    function automatic logic get_ser(input int sel);
        case (sel)
            0:       return if4.tx_serial;
            1:       return if8.tx_serial;
            default: return if868.tx_serial;
        endcase
    endfunction

    function automatic logic get_act(input int sel);
        case (sel)
            0:       return if4.tx_active;
            1:       return if8.tx_active;
            default: return if868.tx_active;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return if4.tx_done;
            1:       return if8.tx_done;
            default: return if868.tx_done;
        endcase
    endfunction

    // Sends one byte and checks every cycle of the frame. Sample k (taken on
    // the falling edge after E0+k) must carry frame bit k/cpb. When mid_k >= 0
    // a DV pulse with byte 0xFF is injected at that sample.
    task automatic send_and_check(input int sel, input int cpb, input logic [7:0] b,
                                  input int mid_k, input string tag);
        logic [9:0] frame;
        int good, act_cnt, done_cnt;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        set_byte(sel, b);
        set_dv(sel, 1'b1);
        @(negedge clk);
        set_dv(sel, 1'b0);
        act_cnt  = 0;
        done_cnt = 0;
        for (int bitn = 0; bitn < 10; bitn++) begin
            good = 0;
            for (int c = 0; c < cpb; c++) begin
                if (get_ser(sel) === frame[bitn]) good++;
                if (get_act(sel) === 1'b1) act_cnt++;
                if (get_done(sel) === 1'b1) done_cnt++;
                if (bitn * cpb + c == mid_k) begin
                    set_byte(sel, 8'hFF);
                    set_dv(sel, 1'b1);
                end else begin
                    set_dv(sel, 1'b0);
                end
                @(negedge clk);
            end
            check($sformatf("%s bit%0d level cycles", tag, bitn), good, cpb);
        end
        check({tag, " active cycles"}, act_cnt, 10 * cpb);
        check({tag, " done during frame"}, done_cnt, 0);
        check({tag, " done at end"}, get_done(sel), 1'b1);
        check({tag, " active at end"}, get_act(sel), 1'b0);
        check({tag, " line at end"}, get_ser(sel), 1'b1);
        @(negedge clk);
        check({tag, " done falls"}, get_done(sel), 1'b0);
        act_cnt = 0;
        repeat (2 * cpb) begin
            @(negedge clk);
            if (get_act(sel) !== 1'b0 || get_ser(sel) !== 1'b1) act_cnt++;
        end
        check({tag, " idle after frame"}, act_cnt, 0);
    endtask

    logic       s_hist [0:89];
    logic       a_hist [0:89];
    logic       d_hist [0:89];
    logic [7:0] dec0, dec1;
    int         bad;

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            set_dv(s, 1'b1);
            set_byte(s, 8'hA5);
        end

        // Reset holds everything idle even with DV asserted.
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++)
                if (get_ser(s) !== 1'b1 || get_act(s) !== 1'b0 || get_done(s) !== 1'b0) bad++;
        end
        check("reset idle outputs", bad, 0);
        for (int s = 0; s < 3; s++) set_dv(s, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post reset serial", get_ser(0), 1'b1);
        check("post reset active", get_act(0), 1'b0);
        check("post reset done", get_done(0), 1'b0);

        // Single byte.
        send_and_check(0, 4, 8'hA5, -1, "a5");

        // All-zero frame with a mid-frame byte change and DV pulse.
        send_and_check(0, 4, 8'h00, 13, "zero_dv_block");

        // Back-to-back with DV held high.
        @(negedge clk);
        set_byte(0, 8'h55);
        set_dv(0, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 90; k++) begin
            s_hist[k] = get_ser(0);
            a_hist[k] = get_act(0);
            d_hist[k] = get_done(0);
            if (k == 0) set_byte(0, 8'h0F);
            if (k == 41) set_dv(0, 1'b0);
            @(negedge clk);
        end
        for (int j = 0; j < 8; j++) begin
            dec0[j] = s_hist[(j + 1) * 4 + 2];
            dec1[j] = s_hist[41 + (j + 1) * 4 + 2];
        end
        check("b2b start0", s_hist[2], 1'b0);
        check("b2b byte0", dec0, 8'h55);
        check("b2b stop0", s_hist[38], 1'b1);
        check("b2b active before cleanup", a_hist[39], 1'b1);
        check("b2b cleanup done", d_hist[40], 1'b1);
        check("b2b cleanup active", a_hist[40], 1'b0);
        check("b2b cleanup line", s_hist[40], 1'b1);
        check("b2b second start at 41", s_hist[41], 1'b0);
        check("b2b second active at 41", a_hist[41], 1'b1);
        check("b2b second done low at 41", d_hist[41], 1'b0);
        check("b2b byte1", dec1, 8'h0F);
        check("b2b stop1", s_hist[41 + 38], 1'b1);
        check("b2b done1", d_hist[81], 1'b1);
        check("b2b idle after", {a_hist[82], d_hist[82], s_hist[82]}, 3'b001);

        // Reset during frame bit 3 of 0x3C at CPB=8.
        @(negedge clk);
        set_byte(1, 8'h3C);
        set_dv(1, 1'b1);
        @(negedge clk);
        set_dv(1, 1'b0);
        repeat (35) @(negedge clk);
        check("midreset active before", get_act(1), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midreset serial async", get_ser(1), 1'b1);
        check("midreset active async", get_act(1), 1'b0);
        check("midreset done async", get_done(1), 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (get_done(1) !== 1'b0 || get_act(1) !== 1'b0 || get_ser(1) !== 1'b1) bad++;
        end
        check("midreset no done or frame", bad, 0);
        send_and_check(1, 8, 8'h81, -1, "after_reset_81");

        // Default divide.
        send_and_check(2, 868, 8'hFF, -1, "cpb868_ff");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
